// File: rtl/sysarray_seq_ctrl.sv
// Operand sequencer for a systolic array: buffers n rows each of A and B,
// streams them row-by-row on start, zero-pads the drain and reports completion.
module sysarray_seq_ctrl #(
    parameter int N = 31,
    parameter int n = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic                 wr_sel,
    input  logic [5:0]           wr_addr,
    input  logic [(N+1)*n-1:0]   wr_data,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 wr_err,
    output logic [6:0]           flg,
    output logic [(N+1)*n-1:0]   arr1,
    output logic [(N+1)*n-1:0]   arr2
);

    localparam int         W    = (N + 1) * n;
    localparam logic [6:0] LAST = 7'(3 * n - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q [n];
    logic [W-1:0]   b_q [n];
    logic [6:0]     flg_q, flg_d;
    logic [W-1:0]   arr1_q, arr1_d;
    logic [W-1:0]   arr2_q, arr2_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           wr_err_q, wr_err_d;

    logic           wr_ok;
    logic [6:0]     rd_idx;
    logic [W-1:0]   rd_a, rd_b;

    always_comb begin
        wr_ok    = wr_en && (state_q == IDLE) && (wr_addr < 6'(n));
        wr_err_d = wr_err_q | (wr_en & ~wr_ok);
    end

    // Row fetched for the next cycle; indices >= n fall through to zero (drain).
    always_comb begin
        rd_idx = (state_q == RUN) ? flg_q + 7'd1 : '0;
        rd_a   = '0;
        rd_b   = '0;
        for (int unsigned i = 0; i < n; i++) begin
            if (rd_idx == 7'(i)) begin
                rd_a = a_q[i];
                rd_b = b_q[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        flg_d   = '0;
        arr1_d  = '0;
        arr2_d  = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    arr1_d  = rd_a;
                    arr2_d  = rd_b;
                end
            end
            RUN: begin
                busy_d = 1'b1;
                if (flg_q == LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    flg_d   = LAST;
                end else begin
                    flg_d  = flg_q + 7'd1;
                    arr1_d = rd_a;
                    arr2_d = rd_b;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            flg_q    <= '0;
            arr1_q   <= '0;
            arr2_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
            for (int unsigned i = 0; i < n; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            flg_q    <= flg_d;
            arr1_q   <= arr1_d;
            arr2_q   <= arr2_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wr_err_q <= wr_err_d;
            for (int unsigned i = 0; i < n; i++) begin
                if (wr_ok && (wr_addr == 6'(i))) begin
                    if (wr_sel) b_q[i] <= wr_data;
                    else        a_q[i] <= wr_data;
                end
            end
        end
    end

    assign flg    = flg_q;
    assign arr1   = arr1_q;
    assign arr2   = arr2_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign wr_err = wr_err_q;

endmodule

// File: tb/tb_sysarray_seq_ctrl.sv
// Bench for sysarray_seq_ctrl: directed vector table, corner-case sequences,
// and random traffic checked against a cycle-indexed behavioural model.
module tb_sysarray_seq_ctrl;

    localparam int NB = 31;
    localparam int NN = 3;
    localparam int W  = (NB + 1) * NN;
    localparam int LASTSTEP = 3 * NN - 2;

    logic          clk = 1'b0;
    logic          rst, wr_en, wr_sel, start;
    logic [5:0]    wr_addr;
    logic [W-1:0]  wr_data;
    logic          busy, done, wr_err;
    logic [6:0]    flg;
    logic [W-1:0]  arr1, arr2;

    int checks   = 0;
    int failures = 0;

    sysarray_seq_ctrl #(.N(NB), .n(NN)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .busy(busy), .done(done), .wr_err(wr_err),
        .flg(flg), .arr1(arr1), .arr2(arr2)
    );

    always #5 clk = ~clk;

    // Model: ph = -1 when idle, else cycles elapsed since the accepted start.
    logic [W-1:0] ma [NN];
    logic [W-1:0] mb [NN];
    logic [W-1:0] sa [NN];
    logic [W-1:0] sb [NN];
    int           ph;
    logic         merr;

    function automatic logic [W-1:0] mkrow(input logic [31:0] x0, x1, x2);
        return {x2, x1, x0};
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic en, sel, input logic [5:0] addr,
                              input logic [W-1:0] data, input logic st, r);
        logic [W-1:0] a0, b0;
        if (r) begin
            for (int i = 0; i < NN; i++) begin ma[i] = '0; mb[i] = '0; end
            ph = -1;
            merr = 1'b0;
            return;
        end
        a0 = ma[0];
        b0 = mb[0];
        if (en) begin
            if (ph == -1 && int'(addr) < NN) begin
                if (sel) mb[addr] = data; else ma[addr] = data;
            end else begin
                merr = 1'b1;
            end
        end
        if (ph == -1) begin
            if (st) begin
                for (int i = 0; i < NN; i++) begin sa[i] = ma[i]; sb[i] = mb[i]; end
                sa[0] = a0;
                sb[0] = b0;
                ph = 0;
            end
        end else if (ph == LASTSTEP + 1) begin
            ph = -1;
        end else begin
            ph++;
        end
    endtask

    task automatic model_compare();
        logic [6:0]   ef;
        logic         eb, ed;
        logic [W-1:0] e1, e2;
        ef = '0; eb = 1'b0; ed = 1'b0; e1 = '0; e2 = '0;
        if (ph >= 0 && ph <= LASTSTEP) begin
            ef = 7'(ph);
            eb = 1'b1;
            if (ph < NN) begin e1 = sa[ph]; e2 = sb[ph]; end
        end else if (ph == LASTSTEP + 1) begin
            ef = 7'(LASTSTEP);
            eb = 1'b1;
            ed = 1'b1;
        end
        check("m_flg",    128'(flg),    128'(ef));
        check("m_busy",   128'(busy),   128'(eb));
        check("m_done",   128'(done),   128'(ed));
        check("m_wr_err", 128'(wr_err), 128'(merr));
        check("m_arr1",   128'(arr1),   128'(e1));
        check("m_arr2",   128'(arr2),   128'(e2));
    endtask

    task automatic cyc(input logic en, sel, input logic [5:0] addr,
                       input logic [W-1:0] data, input logic st, r);
        wr_en = en; wr_sel = sel; wr_addr = addr; wr_data = data; start = st; rst = r;
        @(posedge clk);
        model_edge(en, sel, addr, data, st, r);
        #1;
        model_compare();
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, 6'd0, '0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic         en;
        logic         sel;
        logic [5:0]   addr;
        logic [W-1:0] data;
        logic         st;
        logic [6:0]   flg;
        logic         busy;
        logic         done;
        logic [W-1:0] arr;
    } vec_t;

    function automatic vec_t mkv(input logic en, sel, input logic [5:0] addr,
                                 input logic [W-1:0] data, input logic st,
                                 input logic [6:0] f, input logic b, d,
                                 input logic [W-1:0] a);
        vec_t v;
        v.en = en; v.sel = sel; v.addr = addr; v.data = data; v.st = st;
        v.flg = f; v.busy = b; v.done = d; v.arr = a;
        return v;
    endfunction

    vec_t         tbl [17];
    logic [W-1:0] cap1 [10];
    logic [W-1:0] cap2 [10];
    logic [6:0]   capf [10];

    initial begin
        logic [W-1:0] r0, r1, r2, z;
        r0 = mkrow(1, 2, 3);
        r1 = mkrow(4, 5, 6);
        r2 = mkrow(7, 8, 9);
        z  = '0;
        tbl[0]  = mkv(1, 0, 0, r0, 0, 0, 0, 0, z);
        tbl[1]  = mkv(1, 0, 1, r1, 0, 0, 0, 0, z);
        tbl[2]  = mkv(1, 0, 2, r2, 0, 0, 0, 0, z);
        tbl[3]  = mkv(1, 1, 0, r0, 0, 0, 0, 0, z);
        tbl[4]  = mkv(1, 1, 1, r1, 0, 0, 0, 0, z);
        tbl[5]  = mkv(1, 1, 2, r2, 0, 0, 0, 0, z);
        tbl[6]  = mkv(0, 0, 0, z,  1, 0, 1, 0, r0);   // start at cycle t
        tbl[7]  = mkv(0, 0, 0, z,  0, 1, 1, 0, r1);
        tbl[8]  = mkv(0, 0, 0, z,  0, 2, 1, 0, r2);
        tbl[9]  = mkv(0, 0, 0, z,  1, 3, 1, 0, z);    // start at t+3 ignored
        tbl[10] = mkv(0, 0, 0, z,  0, 4, 1, 0, z);
        tbl[11] = mkv(0, 0, 0, z,  0, 5, 1, 0, z);
        tbl[12] = mkv(0, 0, 0, z,  0, 6, 1, 0, z);
        tbl[13] = mkv(0, 0, 0, z,  0, 7, 1, 0, z);
        tbl[14] = mkv(0, 0, 0, z,  0, 7, 1, 1, z);    // done at t+9
        tbl[15] = mkv(0, 0, 0, z,  1, 0, 0, 0, z);    // start in DONE ignored
        tbl[16] = mkv(0, 0, 0, z,  1, 0, 1, 0, r0);   // start at t+10 runs

        ph = -1;
        merr = 1'b0;
        for (int i = 0; i < NN; i++) begin ma[i] = '0; mb[i] = '0; sa[i] = '0; sb[i] = '0; end

        cyc(1'b0, 1'b0, 6'd0, '0, 1'b0, 1'b1);
        check("rst_flg",  128'(flg),  128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_err",  128'(wr_err), 128'(0));
        check("rst_arr1", 128'(arr1), 128'(0));

        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].en, tbl[i].sel, tbl[i].addr, tbl[i].data, tbl[i].st, 1'b0);
            check($sformatf("tbl%0d_flg", i),  128'(flg),  128'(tbl[i].flg));
            check($sformatf("tbl%0d_busy", i), 128'(busy), 128'(tbl[i].busy));
            check($sformatf("tbl%0d_done", i), 128'(done), 128'(tbl[i].done));
            check($sformatf("tbl%0d_arr1", i), 128'(arr1), 128'(tbl[i].arr));
            check($sformatf("tbl%0d_arr2", i), 128'(arr2), 128'(tbl[i].arr));
        end
        idle(10);

        // Write guards: out-of-range address, then a write during RUN.
        cyc(1'b1, 1'b0, 6'd3, mkrow(99, 99, 99), 1'b0, 1'b0);
        check("guard_addr_err", 128'(wr_err), 128'(1));
        cyc(1'b0, 1'b0, 6'd0, '0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 6'd1, mkrow(55, 55, 55), 1'b0, 1'b0);
        check("guard_run_err", 128'(wr_err), 128'(1));
        idle(9);
        cyc(1'b0, 1'b0, 6'd0, '0, 1'b1, 1'b0);
        idle(1);
        check("guard_row1_kept", 128'(arr1), 128'(mkrow(4, 5, 6)));
        idle(9);

        // Same-cycle write + start: row 2 is used, row 0 is not.
        cyc(1'b1, 1'b0, 6'd2, mkrow(10, 11, 12), 1'b1, 1'b0);
        idle(2);
        check("same_row2_new", 128'(arr1), 128'(mkrow(10, 11, 12)));
        idle(8);
        cyc(1'b1, 1'b0, 6'd0, mkrow(20, 21, 22), 1'b1, 1'b0);
        check("same_row0_old", 128'(arr1), 128'(mkrow(1, 2, 3)));
        idle(9);

        // Reset at flg=4, then a run over the cleared buffers.
        cyc(1'b0, 1'b0, 6'd0, '0, 1'b1, 1'b0);
        idle(4);
        check("mid_flg4", 128'(flg), 128'(4));
        cyc(1'b0, 1'b0, 6'd0, '0, 1'b0, 1'b1);
        check("mid_rst_flg",  128'(flg),  128'(0));
        check("mid_rst_busy", 128'(busy), 128'(0));
        check("mid_rst_arr1", 128'(arr1), 128'(0));
        idle(6);
        cyc(1'b0, 1'b0, 6'd0, '0, 1'b1, 1'b0);
        check("zero_run_arr1", 128'(arr1), 128'(0));
        check("zero_run_busy", 128'(busy), 128'(1));
        idle(9);

        // Re-run without reload yields an identical stream.
        cyc(1'b1, 1'b0, 6'd0, mkrow(31, 32, 33), 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 6'd1, mkrow(41, 42, 43), 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 6'd2, mkrow(51, 52, 53), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 6'd0, '0, (i == 0), 1'b0);
            cap1[i] = arr1; cap2[i] = arr2; capf[i] = flg;
        end
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 6'd0, '0, (i == 0), 1'b0);
            check($sformatf("rerun%0d_arr1", i), 128'(arr1), 128'(cap1[i]));
            check($sformatf("rerun%0d_arr2", i), 128'(arr2), 128'(cap2[i]));
            check($sformatf("rerun%0d_flg", i),  128'(flg),  128'(capf[i]));
        end

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                6'($urandom_range(0, 3)), {$urandom, $urandom, $urandom},
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 79) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sysarray_seq_ctrl.md
Name: sysarray_seq_ctrl

Overview:
- Sequencer that owns the operand buffers for `sysarray` and drives its `arr1`, `arr2` and `flg` inputs.
- The host loads n rows of operand A and n rows of operand B into internal row buffers, then pulses `start`.
- The controller streams row k on step k, zero-pads the array drain, and steps `flg` through the full compute window.
- It signals `done` when the window completes; one controller instance drives one array.

Parameters:
- N, 31, MSB index of one element; element width is N+1 bits.
- n, 3, array dimension (rows/lanes); legal range 2..42, so that 3n-2 fits in 7 bits.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  buffer write strobe
- wr_sel  in  1  0 = A buffer, 1 = B buffer
- wr_addr  in  6  row index, 0..n-1
- wr_data  in  (N+1)*n  packed row; lane j = bits [(j+1)(N+1)-1 : j(N+1)]
- start  in  1  single-cycle request to run one multiplication
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle completion pulse
- wr_err  out  1  sticky; a write was dropped
- flg  out  7  step index to sysarray
- arr1  out  (N+1)*n  A row to sysarray
- arr2  out  (N+1)*n  B row to sysarray

Behaviour:
- Reset (`rst` high at a rising edge):
  - state = IDLE; flg, arr1, arr2, busy, done, wr_err = 0.
  - All 2n buffer rows cleared to 0.
  - Reset applies in any state, including mid-RUN; the next cycle is IDLE with all outputs 0.
- All outputs are registered; none is combinational from the inputs.
- Buffer writes:
  - Accepted only in IDLE, when wr_en=1 and wr_addr<n.
  - The addressed row of the selected buffer is updated at the edge.
  - wr_en=1 with wr_addr>=n, or while busy: write dropped, wr_err set. wr_err clears only on rst.
- States IDLE, RUN, DONE:
  - IDLE: flg=0, arr1=arr2=0, busy=0.
    - start=1 → RUN.
    - At that same edge: step counter=0, flg=0, arr1=A[0], arr2=B[0].
  - RUN: on each edge the step counter s increments.
    - flg=s.
    - For s<n: arr1=A[s], arr2=B[s].
    - For n<=s<=3n-2: arr1=arr2=0 (drain).
    - The window is exactly 3n-1 cycles (flg = 0..3n-2).
    - The edge after the cycle with flg=3n-2 → DONE.
  - DONE: one cycle.
    - done=1, busy=1, arr1=arr2=0, flg holds 3n-2.
    - Next edge → IDLE; flg returns to 0.
- start is ignored in RUN and DONE (no queuing). Back-to-back runs need start in IDLE, so there is a minimum 1 IDLE cycle between runs.
- Simultaneous wr_en and start in IDLE:
  - The write takes effect at the same edge.
  - Rows 1..n-1 written in that cycle are used by the run.
  - Row 0 is not used: arr1/arr2 load the pre-edge buffer value for step 0.
- Buffers persist across runs; a re-run without reloading reuses the old operands.
- Arithmetic: the step counter is 7 bits, with no wrap because of the n bound; no data arithmetic is done in this block.

Test Plan:
- Load/run, n=3: A rows {1,2,3},{4,5,6},{7,8,9} and B identical; start → cycles 1..3 show arr1=arr2 lanes (1,2,3),(4,5,6),(7,8,9) with flg 0,1,2; cycles 4..8 show arr=0 with flg 3..7; done=1 one cycle with flg=7; IDLE next with flg=0.
- Latency: start at cycle t → busy rises t+1, done at t+9, busy falls t+10; second start at t+3 ignored; start at t+10 begins a new run.
- Write guards: wr_addr=3 in IDLE → no buffer change, wr_err=1; write during RUN → buffer unchanged on the next run, wr_err stays 1.
- Same-cycle write+start: write A[2]={10,11,12} together with start → third RUN cycle arr1=(10,11,12); write A[0] together with start → step 0 shows the old A[0].
- Reset mid-run: rst at flg=4 → next cycle flg=0, arr=0, busy=0, done never pulses; a following start streams all-zero rows.
- Re-run: two starts with no reload → identical arr1/arr2/flg sequences.
